// File: rtl/dec_scan_onehot.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a direct-decode mode and an
// autonomous scan mode that walks every output line, holding each dwell+1 cycles.
module dec_scan_onehot #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int N = 1 << SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        ACT_FREEZE,   // disabled: blank outputs, keep idx/cnt
        ACT_LOAD,     // direct decode or scan load: take sel
        ACT_STEP,     // dwell expired: advance to next line
        ACT_HOLD      // still dwelling on the current line
    } act_e;

    act_e               act;
    logic [DWELL_W-1:0] cnt;
    logic [SEL_W-1:0]   idx_inc;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    assign idx_inc = idx + 1'b1;

    // >= rather than == so a dwell lowered below cnt mid-hold steps at once.
    always_comb begin
        // NOTE: a default assignment first means every path drives act, so no latch is inferred.
        act = ACT_HOLD;
        if (!enable)
            act = ACT_FREEZE;
        else if (!mode || load)
            act = ACT_LOAD;
        else if (cnt >= dwell)
            act = ACT_STEP;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values of the others.
        if (!rst_n) begin
            out  <= '0;
            idx  <= '0;
            wrap <= 1'b0;
            cnt  <= '0;
        end else begin
            case (act)
                ACT_FREEZE: begin
                    out  <= '0;
                    wrap <= 1'b0;
                end
                ACT_LOAD: begin
                    idx  <= sel;
                    out  <= onehot(sel);
                    cnt  <= '0;
                    wrap <= 1'b0;
                end
                ACT_STEP: begin
                    idx  <= idx_inc;
                    out  <= onehot(idx_inc);
                    cnt  <= '0;
                    wrap <= (idx == IDX_MAX);
                end
                default: begin
                    out  <= onehot(idx);
                    cnt  <= cnt + 1'b1;
                    wrap <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_scan_onehot.sv
// Directed bench for dec_scan_onehot: expectations are queued as each step is
// driven and popped after the following clock edge, for SEL_W=3 and SEL_W=4.
module tb_dec_scan_onehot;

    logic        clk = 1'b0;
    logic        rst_n, enable, mode, load;
    logic [2:0]  sel3;
    logic [3:0]  sel4;
    logic [7:0]  dwell;
    logic [7:0]  out3;
    logic [2:0]  idx3;
    logic        wrap3;
    logic [15:0] out4;
    logic [3:0]  idx4;
    logic        wrap4;

    int errors = 0;
    int checks = 0;
    bit use4   = 1'b0;

    typedef struct {
        string       tag;
        logic [15:0] out;
        logic [3:0]  idx;
        logic        wrap;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dec_scan_onehot #(.SEL_W(3), .DWELL_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel3),
        .load(load), .dwell(dwell), .out(out3), .idx(idx3), .wrap(wrap3)
    );

    dec_scan_onehot #(.SEL_W(4), .DWELL_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel4),
        .load(load), .dwell(dwell), .out(out4), .idx(idx4), .wrap(wrap4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] oh(input int k);
        return 16'(1) << k;
    endfunction

    // Queue the expectation for the next edge, run the edge, then score it.
    task automatic step(input string tag, input logic [15:0] e_out, input int e_idx, input logic e_wrap);
        exp_t e;
        e.tag  = tag;
        e.out  = e_out;
        e.idx  = 4'(e_idx);
        e.wrap = e_wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (use4) begin
                check({e.tag, "_out"},  32'(out4),  32'(e.out));
                check({e.tag, "_idx"},  32'(idx4),  32'(e.idx));
                check({e.tag, "_wrap"}, 32'(wrap4), 32'(e.wrap));
            end else begin
                check({e.tag, "_out"},  32'(out3),  32'(e.out));
                check({e.tag, "_idx"},  32'(idx3),  32'(e.idx));
                check({e.tag, "_wrap"}, 32'(wrap3), 32'(e.wrap));
            end
        end
    endtask

    always @(negedge clk) begin
        check("onehot0_w3", 32'($onehot0(out3)), 32'd1);
        check("onehot0_w4", 32'($onehot0(out4)), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        mode   = 1'b1;
        load   = 1'b0;
        sel3   = 3'd0;
        sel4   = 4'd0;
        dwell  = 8'd0;

        // Reset held over two edges.
        step("reset0", 16'h0000, 0, 1'b0);
        step("reset1", 16'h0000, 0, 1'b0);

        // Direct decode, one-cycle latency.
        rst_n = 1'b1;
        mode  = 1'b0;
        sel3  = 3'd5;
        step("direct_sel5", 16'h0020, 5, 1'b0);

        // Reset pulsed low between edges must not touch state.
        rst_n = 1'b0;
        #3;
        check("rst_glitch_out", 32'(out3), 32'h20);
        check("rst_glitch_idx", 32'(idx3), 32'd5);
        rst_n = 1'b1;
        sel3  = 3'd0;
        step("direct_sel0", 16'h0001, 0, 1'b0);

        // Disabled: blank output, idx frozen, sel/mode/load ignored.
        enable = 1'b0;
        step("disable0", 16'h0000, 0, 1'b0);
        sel3 = 3'd7;
        load = 1'b1;
        mode = 1'b1;
        step("disable1", 16'h0000, 0, 1'b0);

        // Scan with dwell=0 from idx 0: one line per edge, wrap on return.
        enable = 1'b1;
        sel3   = 3'd0;
        step("scan_d0_load", 16'h0001, 0, 1'b0);
        load = 1'b0;
        for (int k = 1; k <= 9; k++)
            step("scan_d0", oh(k % 8), k % 8, k == 8);

        // Scan with dwell=2: each line held three cycles, wrap after 24.
        load = 1'b1;
        step("scan_d2_load", 16'h0001, 0, 1'b0);
        load  = 1'b0;
        dwell = 8'd2;
        for (int t = 1; t <= 31; t++)
            step("scan_d2", oh((t / 3) % 8), (t / 3) % 8, t == 24);

        // Now idx=2, cnt=1: load line 6 mid-hold.
        load = 1'b1;
        sel3 = 3'd6;
        step("load6", 16'h0040, 6, 1'b0);
        load = 1'b0;
        step("load6_hold1", 16'h0040, 6, 1'b0);

        // Freeze with cnt=1 for five edges.
        enable = 1'b0;
        for (int k = 0; k < 5; k++)
            step("freeze", 16'h0000, 6, 1'b0);

        // Resume from frozen cnt: one more cycle on line 6, then step.
        enable = 1'b1;
        step("resume_hold", 16'h0040, 6, 1'b0);
        step("resume_step", 16'h0080, 7, 1'b0);
        step("resume_h7a",  16'h0080, 7, 1'b0);
        step("resume_h7b",  16'h0080, 7, 1'b0);
        step("resume_wrap", 16'h0001, 0, 1'b1);

        // Dwell shrink: at cnt=50 under dwell=200, drop dwell to 10.
        load  = 1'b1;
        sel3  = 3'd3;
        dwell = 8'd200;
        step("shrink_load", 16'h0008, 3, 1'b0);
        load = 1'b0;
        for (int k = 1; k <= 50; k++)
            step("shrink_hold", 16'h0008, 3, 1'b0);
        dwell = 8'd10;
        step("shrink_step", 16'h0010, 4, 1'b0);
        step("shrink_after", 16'h0010, 4, 1'b0);

        // Maximum dwell: hold for 256 cycles without counter overflow.
        load  = 1'b1;
        sel3  = 3'd7;
        dwell = 8'd255;
        step("maxdw_load", 16'h0080, 7, 1'b0);
        load = 1'b0;
        for (int k = 1; k <= 255; k++)
            step("maxdw_hold", 16'h0080, 7, 1'b0);
        step("maxdw_wrap", 16'h0001, 0, 1'b1);

        // Scan to direct, then direct to scan with full first hold.
        mode  = 1'b0;
        sel3  = 3'd2;
        dwell = 8'd1;
        step("m1to0", 16'h0004, 2, 1'b0);
        mode = 1'b1;
        step("m0to1_hold", 16'h0004, 2, 1'b0);
        step("m0to1_step", 16'h0008, 3, 1'b0);

        // Width variant SEL_W=4.
        use4 = 1'b1;
        mode = 1'b0;
        sel4 = 4'd9;
        step("w4_direct9", 16'h0200, 9, 1'b0);
        sel4 = 4'd0;
        step("w4_direct0", 16'h0001, 0, 1'b0);
        mode  = 1'b1;
        load  = 1'b1;
        dwell = 8'd0;
        step("w4_load0", 16'h0001, 0, 1'b0);
        load = 1'b0;
        for (int t = 1; t <= 32; t++)
            step("w4_scan_d0", oh(t % 16), t % 16, (t % 16) == 0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_scan_onehot.md
Name: dec_scan_onehot

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with an enable input.
- Two modes:
  - Direct mode: decodes a select input, with a one-cycle registered latency.
  - Scan mode: autonomously steps the active output through all 2^SEL_W lines, holding each for a programmable dwell time.
- Intended for digit/row scanning and channel strobing, replacing hand-written fixed-width gate-level decoders in datapath and display logic.

Parameters:
- SEL_W, 3, select width; output width is 2^SEL_W (legal 1..6).
- DWELL_W, 8, width of the dwell count input and internal dwell counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- enable  input  1  1 = outputs active; 0 = all outputs low, state frozen.
- mode  input  1  0 = direct decode; 1 = scan.
- sel  input  SEL_W  select index (direct mode) / load index (scan mode).
- load  input  1  scan mode only: force index to sel.
- dwell  input  DWELL_W  scan mode: each output held dwell+1 cycles.
- out  output  2^SEL_W  registered one-hot decode; all-zero when disabled.
- idx  output  SEL_W  registered current index; out == onehot(idx) whenever out is nonzero.
- wrap  output  1  one-cycle pulse when scan steps from index 2^SEL_W-1 to 0.

Behaviour:
- All state updates on the clk rising edge; no combinational input-to-output paths.
- Reset (rst_n=0 at edge): out=0, idx=0, wrap=0, dwell counter cnt=0. Reset has no effect between edges.
- Priority per edge: reset > enable=0 > load (mode=1) > mode behaviour.
- enable=0:
  - out<=0 and wrap<=0.
  - idx and cnt hold.
  - load, sel and mode are ignored.
- enable=1, mode=0 (direct):
  - idx<=sel, out<=onehot(sel), cnt<=0, wrap<=0.
  - Latency is 1 cycle from sel to out.
- enable=1, mode=1, load=1:
  - idx<=sel, out<=onehot(sel), cnt<=0, wrap<=0.
  - No step occurs that cycle.
- enable=1, mode=1, load=0:
  - If cnt >= dwell:
    - cnt<=0, idx<=idx+1 modulo 2^SEL_W, out<=onehot(idx+1).
    - wrap<=1 iff idx was 2^SEL_W-1.
  - Else: cnt<=cnt+1, idx holds, out<=onehot(idx), wrap<=0.
- The step comparison uses >=, so lowering dwell below the current cnt mid-hold steps on the next edge rather than overflowing.
- dwell=0 steps every cycle; dwell=2^DWELL_W-1 holds for 2^DWELL_W cycles. cnt never exceeds 2^DWELL_W-1.
- Mode 0 -> 1 transition: scan starts from the idx last decoded, with cnt=0, so the first hold is a full dwell+1 cycles.
- Mode 1 -> 0 transition: direct decode takes effect on the next edge.
- Re-enable after enable=0:
  - out<=onehot(idx) on the first enabled edge.
  - The scan count continues from the frozen cnt.
- out is always exactly one-hot or all-zero. Any other value is a bug; the bench asserts $onehot0(out) every cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with enable=1, mode=1 -> out=0x00, idx=0, wrap=0. Driving rst_n low between edges changes nothing until the next edge.
- Direct decode (SEL_W=3): enable=1, mode=0, sel=5 -> out=0x20, idx=5 one edge later. Then sel=0 -> out=0x01. Then enable=0 -> out=0x00 while idx stays 0.
- Scan with dwell=0, starting from idx=0 -> out sequence 0x01,0x02,0x04,...,0x80,0x01 on successive edges. wrap=1 only in the cycle where out returns to 0x01.
- Scan with dwell=2 -> each of 0x01,0x02,... is held exactly 3 cycles. A 24-cycle run completes one wrap.
- Load mid-scan: at cnt=1 on idx=2, pulse load with sel=6 -> out=0x40 next edge and is held 3 full cycles, with no wrap. Then enable=0 for 5 cycles -> out=0x00. Re-enable -> out=0x40 and the scan resumes from the frozen cnt.
- Dwell shrink and width variant: with dwell=200 at cnt=50, set dwell=10 -> step on the next edge. Repeat the direct and dwell=0 scan tests with SEL_W=4 -> 16-line sequence 0x0001..0x8000, with wrap every 16 cycles.
